// File: rtl/seg_display_conditioner.sv
// rtl/seg_display_conditioner.sv - 7-seg output stage: double-letter gap, PWM (SEG_CONDITIONER_PWM_EN), blink
module seg_display_conditioner #(
    parameter int GAP_LEN    = 1024,
    parameter int GAP_W      = 10,
    parameter int BLINK_BITS = 22
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [7:0] seg_in,
    input  logic       seg_valid,
    input  logic [2:0] brightness,
    input  logic       blink_en,
    output logic [7:0] seg_out,
    output logic       busy
);

    typedef enum logic {SHOW = 1'b0, GAP = 1'b1} state_t;

    state_t                state;
    state_t                state_nxt;
    logic [7:0]            cur_pat;
    logic [GAP_W-1:0]      gap_cnt;
    logic [BLINK_BITS-1:0] blink_cnt;
    logic                  take_new;
    logic                  take_gap;
    logic                  pwm_off;
    logic                  blank;

    // A repeat of the all-off pattern needs no gap; it is already blank.
    always_comb begin
        take_new = (state == SHOW) && seg_valid && (seg_in != cur_pat);
        take_gap = (state == SHOW) && seg_valid && (seg_in == cur_pat) && (seg_in != 8'hFF);
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) state <= SHOW;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            SHOW: if (take_gap)      state_nxt = GAP;
            GAP:  if (gap_cnt == '0) state_nxt = SHOW;
            default:                 state_nxt = SHOW;
        endcase
    end

    always_comb begin
        busy = (state == GAP);
    end

`ifdef SEG_CONDITIONER_PWM_EN
    logic [2:0] pwm_cnt;

    always_ff @(posedge CLK) begin
        if (!RST_N) pwm_cnt <= 3'd0;
        else        pwm_cnt <= pwm_cnt + 3'd1;
    end

    assign pwm_off = (pwm_cnt > brightness);
`else
    logic unused_brightness;
    assign unused_brightness = ^brightness;
    assign pwm_off           = 1'b0;
`endif

    assign blank = busy | pwm_off | (blink_en & blink_cnt[BLINK_BITS-1]);

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            cur_pat   <= 8'hFF;
            gap_cnt   <= '0;
            blink_cnt <= '0;
            seg_out   <= 8'hFF;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
            if (take_new)
                cur_pat <= seg_in;
            if (take_gap)
                gap_cnt <= GAP_W'(GAP_LEN - 1);
            else if (state == GAP && gap_cnt != '0)
                gap_cnt <= gap_cnt - 1'b1;
            seg_out <= blank ? 8'hFF : cur_pat;
        end
    end

endmodule

// File: doc/seg_display_conditioner.md
Name: seg_display_conditioner

Overview:
- Output stage sitting directly downstream of the letter-pattern generator. It consumes 8-bit common-anode segment patterns (bit order xGFEDCBA, segment lit when its bit is 0) and drives the 7-segment pins.
- Inserts a timed blank gap between consecutive identical letters, so that a double letter such as "LL" reads as two letters.
- Applies PWM brightness and an optional global blink.
- All outputs are registered.

Parameters:
- GAP_LEN, 1024, number of CLK cycles the display is blanked between two identical letters (minimum 1).
- GAP_W, 10, width of the gap counter; must satisfy 2^GAP_W >= GAP_LEN.
- BLINK_BITS, 22, width of the free-running blink counter; its MSB is the blink phase.

Ports:
- CLK  input  1  single system clock, rising-edge.
- RST_N  input  1  reset, synchronous, active-low.
- seg_in  input  8  incoming pattern, common-anode, xGFEDCBA.
- seg_valid  input  1  strobe; seg_in is sampled on any rising CLK edge where this is 1.
- brightness  input  3  PWM level, 0 = dimmest, 7 = full.
- blink_en  input  1  1 = blank the output during the blink-off phase.
- seg_out  output  8  registered pattern to the pins; 8'hFF = all segments off.
- busy  output  1  1 while in GAP; seg_valid is ignored while busy = 1.

Behaviour:
- Reset: applies at any rising CLK edge with RST_N = 0, including mid-GAP. Results after that edge:
  - cur_pat = 8'hFF, state = SHOW.
  - gap_cnt = 0, pwm_cnt = 0, blink_cnt = 0.
  - seg_out = 8'hFF, busy = 0.
- FSM has two states, SHOW and GAP.
- SHOW, at an edge with seg_valid = 1:
  - seg_in != cur_pat: cur_pat <= seg_in; stay in SHOW.
  - seg_in == cur_pat and seg_in != 8'hFF: state <= GAP, gap_cnt <= GAP_LEN-1; cur_pat unchanged.
  - seg_in == cur_pat == 8'hFF: no action.
- GAP:
  - Each edge: if gap_cnt != 0, decrement gap_cnt; if gap_cnt == 0, state <= SHOW.
  - GAP therefore lasts exactly GAP_LEN cycles.
  - seg_valid is dropped (no capture, no queueing). Upstream must hold off while busy = 1.
- busy = 1 exactly when state == GAP; it is combinational from the state register.
- Output stage, computed every edge:
  - blank = (state == GAP) | pwm_off | (blink_en & blink_cnt[BLINK_BITS-1]).
  - seg_out <= blank ? 8'hFF : cur_pat.
  - All 8 bits are treated uniformly, including the DP bit.
- Latency:
  - A new differing pattern captured at edge N appears on seg_out at edge N+1.
  - GAP entry at edge N blanks seg_out at edge N+1.
  - The repeated letter reappears at edge N+GAP_LEN+1.
- PWM: pwm_cnt is a free-running 3-bit counter that wraps 7 -> 0. pwm_off = (pwm_cnt > brightness).
  - Duty is (brightness+1)/8; brightness 7 gives always on.
  - brightness may change at any cycle and takes effect on the next edge.
- Blink: blink_cnt is free-running and wraps to 0 at all-ones. It is never reset by seg_valid or by FSM activity.
- Simultaneous events: reset has priority over everything else. GAP expiry and seg_valid on the same edge: seg_valid is dropped, because busy = 1 on that edge.

Optional Feature:
- Macro: SEG_CONDITIONER_PWM_EN.
- Defined: PWM behaves as described above.
- Undefined: pwm_cnt is not implemented, pwm_off is fixed at 0, and the brightness port is present but ignored (the display runs at full duty).

Test Plan:
- Reset: RST_N = 0 for 2 cycles, then 1, with brightness = 7 and blink_en = 0 -> seg_out = 8'hFF and busy = 0 on the edge after reset. Also assert RST_N = 0 during GAP -> busy = 0 and seg_out = 8'hFF on the next edge.
- Distinct letters: GAP_LEN = 4, brightness = 7. seg_valid with 8'h89, then 8'h86 one cycle later -> seg_out = 8'h89 at N+1 and 8'h86 at N+2; busy stays 0.
- Double letter: seg_valid with 8'hC7 at edge N, then 8'hC7 again at edge M -> seg_out = 8'hFF from M+1 through M+4, busy = 1 for 4 cycles, and seg_out = 8'hC7 at M+5.
- Dropped input: during GAP apply seg_valid with 8'hC0 -> seg_out returns to 8'hC7 after the gap and 8'hC0 never appears; a later seg_valid with 8'hC0 in SHOW is shown.
- PWM (macro defined): brightness = 2 with a steady 8'h88 -> exactly 3 of every 8 cycles show 8'h88 and 5 show 8'hFF. With the macro undefined -> 8'h88 on every cycle.
- Blink: BLINK_BITS = 4, blink_en = 1, pattern 8'h92 -> seg_out alternates 8 cycles 8'h92 / 8 cycles 8'hFF; clearing blink_en restores a steady 8'h92 on the next edge.
